// File: rtl/seq_alu_pkg.sv
// Shared widths, opcode encodings, flag bit positions and FSM states for seq_alu.
package seq_alu_pkg;

  localparam int unsigned aluwidth = 8;
  localparam int unsigned opsize   = 4;
  localparam int unsigned numflags = 4;

  // Bit positions inside the {C V Z N} flag vector
  localparam int unsigned FLAG_C = 3;
  localparam int unsigned FLAG_V = 2;
  localparam int unsigned FLAG_Z = 1;
  localparam int unsigned FLAG_N = 0;

  typedef enum logic [opsize-1:0] {
    OP_ADD = opsize'(0),
    OP_SUB = opsize'(1),
    OP_AND = opsize'(2),
    OP_OR  = opsize'(3),
    OP_LS  = opsize'(4),
    OP_RS  = opsize'(5),
    OP_ASR = opsize'(6),
    OP_MUL = opsize'(7)
  } opcode_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_MUL
  } state_e;

  // Z and N always follow the result; C and V are supplied by the operation
  function automatic logic [numflags-1:0] mk_flags(input logic c, input logic v,
                                                   input logic [aluwidth-1:0] res);
    logic [numflags-1:0] f;
    f         = '0;
    f[FLAG_C] = c;
    f[FLAG_V] = v;
    f[FLAG_Z] = (res == '0);
    f[FLAG_N] = res[aluwidth-1];
    return f;
  endfunction

endpackage

// File: rtl/seq_mul_unit.sv
// Iterative unsigned shift-add multiplier, one multiplier bit per cycle, LSB first.
// The load cycle already consumes bit 0, so finished rises aluwidth-1 edges after load.
module seq_mul_unit
  import seq_alu_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [aluwidth-1:0]   a,
  input  logic [aluwidth-1:0]   b,
  output logic [2*aluwidth-1:0] product,
  output logic                  finished
);

  localparam int unsigned PW    = 2 * aluwidth;
  localparam int unsigned CNT_W = $clog2(aluwidth) + 1;

  logic [PW-1:0]       mcand_q, mcand_d;
  logic [aluwidth-1:0] mplier_q, mplier_d;
  logic [PW-1:0]       acc_q, acc_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                fin_q, fin_d;

  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    fin_d    = fin_q;
    if (load) begin
      mcand_d  = PW'(a) << 1;
      mplier_d = b >> 1;
      acc_d    = b[0] ? PW'(a) : '0;
      cnt_d    = CNT_W'(1);
      fin_d    = 1'b0;
    end else if (!fin_q && (cnt_q != '0)) begin
      acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CNT_W'(1);
      fin_d    = (cnt_d == CNT_W'(aluwidth));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      fin_q    <= 1'b0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      fin_q    <= fin_d;
    end
  end

  assign product  = acc_q;
  assign finished = fin_q;

endmodule

// File: rtl/seq_alu.sv
// Registered, start/done handshaked ALU; single-cycle ops finish on the accepting edge,
// MUL runs through seq_mul_unit. S_EXEC is the done cycle, during which start is ignored.
module seq_alu
  import seq_alu_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [opsize-1:0]   opcode,
  input  logic [aluwidth-1:0] in1,
  input  logic [aluwidth-1:0] in2,
  output logic                busy,
  output logic                done,
  output logic [aluwidth-1:0] out,
  output logic [numflags-1:0] flags
);

  localparam int unsigned MSB = aluwidth - 1;
  localparam int unsigned SHW = $clog2(aluwidth);

  state_e                state_q, state_d;
  logic [aluwidth-1:0]   out_q, out_d;
  logic [numflags-1:0]   flags_q, flags_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic                  mul_load;
  logic [2*aluwidth-1:0] mul_product;
  logic                  mul_finished;

  logic [aluwidth:0]     sum;
  logic [aluwidth:0]     diff;
  logic [SHW-1:0]        sh;
  logic                  sh_big;
  logic [aluwidth-1:0]   exec_res;
  logic                  exec_c;
  logic                  exec_v;

  seq_mul_unit u_mul (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (mul_load),
    .a        (in1),
    .b        (in2),
    .product  (mul_product),
    .finished (mul_finished)
  );

  // Single-cycle datapath; shift amounts at or beyond the width saturate
  always_comb begin
    sum      = {1'b0, in1} + {1'b0, in2};
    diff     = {1'b0, in1} - {1'b0, in2};
    sh       = in2[SHW-1:0];
    sh_big   = (32'(in2) >= aluwidth);
    exec_res = '0;
    exec_c   = 1'b0;
    exec_v   = 1'b0;
    case (opcode)
      OP_ADD: begin
        exec_res = sum[aluwidth-1:0];
        exec_c   = sum[aluwidth];
        exec_v   = (in1[MSB] == in2[MSB]) && (exec_res[MSB] != in1[MSB]);
      end
      OP_SUB: begin
        exec_res = diff[aluwidth-1:0];
        exec_c   = diff[aluwidth];
        exec_v   = (in1[MSB] != in2[MSB]) && (exec_res[MSB] != in1[MSB]);
      end
      OP_AND:  exec_res = in1 & in2;
      OP_OR:   exec_res = in1 | in2;
      OP_LS:   exec_res = sh_big ? '0 : (in1 << sh);
      OP_RS:   exec_res = sh_big ? '0 : (in1 >> sh);
      OP_ASR:  exec_res = sh_big ? {aluwidth{in1[MSB]}} : aluwidth'($signed(in1) >>> sh);
      default: exec_res = '0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    out_d    = out_q;
    flags_d  = flags_q;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    mul_load = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (opcode == OP_MUL) begin
            state_d  = S_MUL;
            mul_load = 1'b1;
            busy_d   = 1'b1;
          end else begin
            state_d = S_EXEC;
            out_d   = exec_res;
            flags_d = mk_flags(exec_c, exec_v, exec_res);
            done_d  = 1'b1;
          end
        end
      end
      S_EXEC: state_d = S_IDLE;
      S_MUL: begin
        if (mul_finished) begin
          state_d = S_EXEC;
          out_d   = mul_product[aluwidth-1:0];
          flags_d = mk_flags(|mul_product[2*aluwidth-1:aluwidth], 1'b0,
                             mul_product[aluwidth-1:0]);
          done_d  = 1'b1;
        end else begin
          busy_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      out_q   <= '0;
      flags_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      flags_q <= flags_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign out   = out_q;
  assign flags = flags_q;

endmodule

// File: tb/tb_seq_alu.sv
// Directed self-checking bench for seq_alu with hand-computed expected results.
module tb_seq_alu;
  import seq_alu_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [3:0] opcode;
  logic [7:0] in1;
  logic [7:0] in2;
  logic       busy;
  logic       done;
  logic [7:0] out;
  logic [3:0] flags;

  int n_checks = 0;
  int n_fail   = 0;

  seq_alu dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .opcode (opcode),
    .in1    (in1),
    .in2    (in2),
    .busy   (busy),
    .done   (done),
    .out    (out),
    .flags  (flags)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One-cycle start pulse; result must be visible in the very next cycle
  task automatic exec_op(input string tag, input logic [3:0] op, input logic [7:0] a,
                         input logic [7:0] b, input logic [7:0] eo, input logic [3:0] ef);
    @(negedge clk);
    opcode = op; in1 = a; in2 = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({tag, " done"}, 32'(done), 32'd1);
    chk({tag, " busy"}, 32'(busy), 32'd0);
    chk({tag, " out"}, 32'(out), 32'(eo));
    chk({tag, " flags"}, 32'(flags), 32'(ef));
    @(negedge clk);
    chk({tag, " pulse"}, 32'(done), 32'd0);
  endtask

  task automatic mul_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] eo, input logic [3:0] ef);
    int cycles   = 0;
    int busy_cnt = 0;
    bit got      = 1'b0;
    @(negedge clk);
    opcode = OP_MUL; in1 = a; in2 = b; start = 1'b1;
    for (int c = 1; c <= 20 && !got; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) begin
        got    = 1'b1;
        cycles = c;
      end else if (busy) begin
        busy_cnt++;
      end
    end
    chk({tag, " latency"}, 32'(cycles), 32'd9);
    chk({tag, " busy cycles"}, 32'(busy_cnt), 32'd8);
    chk({tag, " out"}, 32'(out), 32'(eo));
    chk({tag, " flags"}, 32'(flags), 32'(ef));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int dones;
    int first_done;
    rst_n = 1'b0; start = 1'b0; opcode = '0; in1 = '0; in2 = '0;
    #12;
    chk("reset out", 32'(out), 32'd0);
    chk("reset flags", 32'(flags), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    exec_op("add ff+01", OP_ADD, 8'hFF, 8'h01, 8'h00, 4'b1010);
    exec_op("add 7f+01", OP_ADD, 8'h7F, 8'h01, 8'h80, 4'b0101);
    exec_op("sub 80-01", OP_SUB, 8'h80, 8'h01, 8'h7F, 4'b0100);
    exec_op("sub 01-02", OP_SUB, 8'h01, 8'h02, 8'hFF, 4'b1001);
    exec_op("and", OP_AND, 8'hF0, 8'h3C, 8'h30, 4'b0000);
    exec_op("or", OP_OR, 8'h80, 8'h01, 8'h81, 4'b0001);
    exec_op("ls 81<<8", OP_LS, 8'h81, 8'd8, 8'h00, 4'b0010);
    exec_op("ls 81<<1", OP_LS, 8'h81, 8'd1, 8'h02, 4'b0000);
    exec_op("asr 80>>>3", OP_ASR, 8'h80, 8'd3, 8'hF0, 4'b0001);
    exec_op("asr 80>>>9", OP_ASR, 8'h80, 8'd9, 8'hFF, 4'b0001);
    exec_op("asr 40>>>200", OP_ASR, 8'h40, 8'd200, 8'h00, 4'b0010);
    exec_op("rs 80>>3", OP_RS, 8'h80, 8'd3, 8'h10, 4'b0000);
    exec_op("rs ff>>8", OP_RS, 8'hFF, 8'd8, 8'h00, 4'b0010);
    exec_op("undef op", 4'hF, 8'h12, 8'h34, 8'h00, 4'b0010);

    mul_op("mul 10*10", 8'h10, 8'h10, 8'h00, 4'b1010);
    mul_op("mul 05*03", 8'h05, 8'h03, 8'h0F, 4'b0000);
    mul_op("mul ff*ff", 8'hFF, 8'hFF, 8'h01, 4'b1000);

    // start held through the done cycle is only taken again one cycle later
    @(negedge clk);
    opcode = OP_ADD; in1 = 8'h01; in2 = 8'h01; start = 1'b1;
    @(negedge clk);
    chk("held done1", 32'(done), 32'd1);
    @(negedge clk);
    chk("held gap", 32'(done), 32'd0);
    @(negedge clk);
    chk("held done2", 32'(done), 32'd1);
    chk("held out", 32'(out), 32'h02);
    start = 1'b0;
    @(negedge clk);
    chk("held after", 32'(done), 32'd0);

    // ADD issued mid-MUL must be dropped, with new operands on the bus
    @(negedge clk);
    opcode = OP_MUL; in1 = 8'h05; in2 = 8'h03; start = 1'b1;
    dones = 0; first_done = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (done) begin
        dones++;
        if (first_done == 0) first_done = c;
      end
      start = 1'b0;
      if (c == 3) begin
        opcode = OP_ADD; in1 = 8'h01; in2 = 8'h01; start = 1'b1;
      end
    end
    chk("ignore dones", 32'(dones), 32'd1);
    chk("ignore latency", 32'(first_done), 32'd9);
    chk("ignore out", 32'(out), 32'h0F);
    chk("ignore flags", 32'(flags), 32'h0);

    // Reset in the middle of a MUL
    @(negedge clk);
    opcode = OP_MUL; in1 = 8'h10; in2 = 8'h10; start = 1'b1;
    repeat (4) begin
      @(negedge clk);
      start = 1'b0;
    end
    chk("abort busy before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort out", 32'(out), 32'd0);
    chk("abort flags", 32'(flags), 32'd0);
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort done", 32'(done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    repeat (15) begin
      @(negedge clk);
      if (done) dones++;
    end
    chk("abort no done", 32'(dones), 32'd0);
    chk("abort idle", 32'(busy), 32'd0);
    exec_op("add after abort", OP_ADD, 8'h02, 8'h03, 8'h05, 4'b0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Registered, handshaked successor to the combinational ALU.
- Same opcode set: ADD, SUB, AND, OR, LS, RS. Adds ASR (arithmetic right shift) and MUL (iterative shift-add multiply, low half of the product).
- Result and flags {C V Z N} are held in registers.
- Sits between the register file read stage and writeback. The controller issues with start and waits for done.

Parameters:
- aluwidth, 8, operand/result width in bits.
- opsize, 4, opcode width.
- numflags, 4, flag vector width; order is {C V Z N}.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  issue request; sampled only while busy=0.
- opcode  input  opsize  operation select.
- in1  input  aluwidth  operand A.
- in2  input  aluwidth  operand B; shift amount for LS/RS/ASR.
- busy  output  1  high from the first edge after an accepted start until done.
- done  output  1  one-cycle pulse; out and flags are valid and updated on this cycle.
- out  output  aluwidth  registered result; holds until the next done.
- flags  output  numflags  registered {C V Z N}; holds until the next done.

Behaviour:
- Reset: asynchronous on rst_n=0.
  - out=0, flags=0, busy=0, done=0.
  - FSM goes to IDLE; multiplier count and partial-product registers clear.
  - Reset during MUL aborts the operation; no done is produced after release.
- FSM states: IDLE, EXEC, MUL.
  - IDLE, start=1: latch opcode, in1, in2. If opcode=MUL go to MUL, otherwise go to EXEC.
  - EXEC: compute from latched operands, register out/flags, pulse done, return to IDLE. Latency is 1 edge after the accepted start, so done is high in the cycle after start.
  - MUL: aluwidth iterations, one multiplier bit per cycle (LSB first). After the last iteration, register out/flags, pulse done, return to IDLE. done arrives aluwidth+1 edges after start.
- busy=1 in EXEC and MUL; busy=0 in the done cycle.
- start while busy=1 is ignored: not queued, no effect on the in-flight operation.
- start asserted in the same cycle as done is not accepted. It must be held and is sampled on the next cycle.
- Arithmetic and width rules:
  - ADD: aluwidth+1-bit sum. C = carry out. V = operands have the same sign and the result sign differs.
  - SUB: in1-in2. C = borrow (1 when in1<in2 unsigned). V = operands have different signs and the result sign differs from in1.
  - AND, OR: C=0, V=0.
  - LS, RS: logical shifts. ASR: sign-filling shift. For all three, in2 >= aluwidth gives 0, or all-ones for ASR of a negative in1. C=0, V=0.
  - MUL: unsigned; out = low aluwidth bits of the product. C = 1 if the high half is nonzero. V=0.
  - Z = (out==0). N = out[aluwidth-1]. These apply to every operation.
  - Undefined opcode: takes the EXEC path; out=0, flags=4'b0010, done still pulses.

Decomposition:
- Opcode defines (ADD, SUB, AND, OR, LS, RS, ASR, MUL) go in the shared parameters include, alongside aluwidth, opsize and numflags.
- Flag bit index constants also go in that include.
- One sub-module, seq_mul_unit, holds the iterative shift-add datapath.
  - Inputs: clk, rst_n, load, a, b.
  - Outputs: product (2*aluwidth), finished.
- The FSM and single-cycle datapath stay in seq_alu.

Test Plan (aluwidth=8):
- ADD in1=0xFF, in2=0x01, start 1 cycle -> done next cycle; out=0x00, flags=4'b1010.
- SUB in1=0x80, in2=0x01 -> out=0x7F, flags=4'b0100. Then SUB 0x01-0x02 -> out=0xFF, flags=4'b1001.
- MUL in1=0x10, in2=0x10 -> busy for 8 cycles, done 9 edges after start, out=0x00, flags=4'b1010. MUL 0x05*0x03 -> out=0x0F, flags=4'b0000.
- Shifts: LS 0x81 by 8 -> 0x00, flags 4'b0010. ASR 0x80 by 3 -> 0xF0, flags 4'b0001. RS 0x80 by 3 -> 0x10.
- start pulsed with ADD in cycle 3 of a running MUL -> ignored; MUL result is unchanged, exactly one done.
- rst_n low at cycle 4 of MUL -> out, flags, busy, done are 0 immediately; no done after release; next ADD 0x02+0x03 -> 0x05.
